screen_code_arbiter: RTL and testbench
======================================

Name: screen_code_arbiter

Overview:
- Shares the 5-bit screen-code path between N_REQ hardware requesters (game FSM, robot link, menu logic) and Nios software.
- Drives the screen_code bus that feeds the screen-code input PIO and the VGA overlay.
- Round-robin arbitration with a minimum display-hold time, plus a software override.
- Avalon-MM slave for control and status, with one-cycle registered read latency, same as the PIO read path.

Parameters:
- N_REQ, 4, number of hardware requesters (2..8).
- CODE_W, 5, screen-code width.
- MIN_HOLD, 16, minimum cycles a granted code stays on screen_code before re-arbitration (>=1).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  2  Avalon register select.
- write  in  1  Avalon write strobe.
- writedata  in  32  Avalon write data.
- readdata  out  32  Avalon read data, registered.
- req  in  N_REQ  per-requester request level.
- req_code  in  N_REQ*CODE_W  flattened codes; requester i occupies bits [i*CODE_W +: CODE_W].
- grant  out  N_REQ  one-hot, one-cycle acknowledge pulse.
- screen_code  out  CODE_W  current displayed code.
- irq  out  1  change interrupt (only meaningful with IRQ_EN).

Behaviour:
- Reset values: readdata=0, grant=0, screen_code=0, irq=0, ctrl=0, status=0, rr_ptr=0, hold_cnt=0, state=IDLE.
- Register map, reads registered one cycle, unused bits read 0:
  - addr0: screen_code, RO.
  - addr1: ctrl. bit0 arb_en, bit1 sw_force, [12:8] sw_code. RW.
  - addr2: status. bit0 chg, [8+N_REQ-1:8] last_grant one-hot. Write 1 to bit0 clears chg.
  - addr3: irq_mask bit0 (IRQ_EN only).
- FSM states: IDLE, HOLD.
  - IDLE, arb_en=1, sw_force=0, |req:
    - pick the first requester at or after rr_ptr, cyclically.
    - Next cycle: grant[i]=1 for exactly one cycle, screen_code=req_code[i], last_grant updated, rr_ptr=(i+1) mod N_REQ, hold_cnt=MIN_HOLD-1, go to HOLD.
    - Arbitration latency: 1 cycle from req sampled to grant.
  - HOLD: hold_cnt decrements each cycle. When it reaches 0, go to IDLE. Requests are ignored, not queued; requesters keep req high until granted.
  - MIN_HOLD=1: HOLD lasts one cycle, so back-to-back grants occur every 2 cycles.
- sw_force=1, from any state:
  - next cycle screen_code=sw_code, state=IDLE, hold_cnt=0, no grants while sw_force=1.
  - Writing new sw_code while forced updates screen_code next cycle.
  - Clearing sw_force resumes arbitration from rr_ptr.
- arb_en=0: no new grants. An in-progress HOLD completes. screen_code retains its value.
- chg sets whenever screen_code changes value. Re-granting an identical code does not set chg.
  - Same-cycle chg set and W1C clear: set wins.
- Reset mid-HOLD: all state returns to reset values immediately, asynchronously; grant deasserts.
- Avalon write to addr0: ignored.

Optional Feature:
- Macro: SCREEN_ARB_IRQ_EN.
- Defined: irq = chg & irq_mask, registered. addr3 is implemented.
- Undefined: irq tied to 0, addr3 reads 0 and writes are ignored, mask flop not synthesised.

Decomposition:
- Shared package screen_arb_pkg holds:
  - register address constants REG_CODE=0, REG_CTRL=1, REG_STATUS=2, REG_IRQMASK=3.
  - ctrl bit positions (CTRL_ARB_EN=0, CTRL_SW_FORCE=1, CTRL_SW_CODE_LSB=8).
  - state enum {IDLE, HOLD}.
- One sub-module: rr_picker. Combinational round-robin priority pick from req and rr_ptr; outputs valid and index.

Test Plan:
- Reset, then read addr0/1/2 -> all 0. grant=0, screen_code=0.
- arb_en=1; req=4'b0110 with codes 3 and 9, MIN_HOLD=16:
  - grant=0010 one cycle later, screen_code=3.
  - next grant=0100 exactly 16 cycles after the first, screen_code=9.
  - rr_ptr wraps to 3.
- All four requesting continuously -> grant order 0,1,2,3,0; no requester granted twice before all others.
- In mid-HOLD, write ctrl=0x1203 (force, sw_code=0x12):
  - next cycle screen_code=0x12, no grants.
  - write ctrl=0x0001 -> arbitration resumes at rr_ptr.
- Same code re-granted -> chg stays 0. New code -> chg=1. W1C on the same cycle as a new change -> chg remains 1.
- With SCREEN_ARB_IRQ_EN, irq_mask=1: a code change raises irq the cycle after chg; W1C deasserts it. Reset asserted mid-HOLD clears irq and grant immediately.

Source files
------------

// File: rtl/screen_arb_pkg.sv
// Shared constants and types for the screen-code arbiter: register map,
// ctrl/status bit positions and the arbitration state encoding.
package screen_arb_pkg;

  localparam logic [1:0] REG_CODE    = 2'd0;
  localparam logic [1:0] REG_CTRL    = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_IRQMASK = 2'd3;

  localparam int CTRL_ARB_EN      = 0;
  localparam int CTRL_SW_FORCE    = 1;
  localparam int CTRL_SW_CODE_LSB = 8;

  localparam int STATUS_CHG       = 0;
  localparam int STATUS_GRANT_LSB = 8;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  // Width needed to index/count up to n-1, never less than one bit.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin pick: first asserted req at or after ptr,
// wrapping cyclically; valid is low when no requester is active.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic             valid,
  output logic [PTR_W-1:0] index
);

  logic [N_REQ-1:0] rot;
  logic [PTR_W-1:0] offset;
  logic [PTR_W:0]   sum;

  // Rotating a doubled copy puts requester ptr at bit 0.
  assign rot = N_REQ'({req, req} >> ptr);

  always_comb begin
    valid  = 1'b0;
    offset = '0;
    for (int b = N_REQ - 1; b >= 0; b--) begin
      if (rot[b]) begin
        valid  = 1'b1;
        offset = PTR_W'(b);
      end
    end
  end

  assign sum   = {1'b0, ptr} + {1'b0, offset};
  assign index = (sum >= (PTR_W + 1)'(N_REQ)) ? PTR_W'(sum - (PTR_W + 1)'(N_REQ))
                                              : sum[PTR_W-1:0];

endmodule

// File: rtl/screen_code_arbiter.sv
// Round-robin screen-code arbiter with minimum hold, software override and an
// Avalon-MM control slave. Define SCREEN_ARB_IRQ_EN for the masked change irq.
module screen_code_arbiter
  import screen_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int CODE_W   = 5,
  parameter int MIN_HOLD = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [1:0]                address,
  input  logic                      write,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*CODE_W-1:0]   req_code,
  output logic [N_REQ-1:0]          grant,
  output logic [CODE_W-1:0]         screen_code,
  output logic                      irq
);

  localparam int PTR_W  = ptr_width(N_REQ);
  localparam int HOLD_W = ptr_width(MIN_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MIN_HOLD - 1);
  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0]  GRANT_ONE = N_REQ'(1);

  // Handshake: Avalon writes complete on the edge where write is high (no wait
  // states); readdata shows the register addressed at the previous edge.
  // Requesters hold req until their one-cycle grant pulse; nothing is queued.

  arb_state_t          state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [PTR_W-1:0]    rr_ptr;
  logic [PTR_W-1:0]    pick_idx;
  logic                pick_valid;
  logic                arb_en;
  logic                sw_force;
  logic [CODE_W-1:0]   sw_code;
  logic                chg;
  logic [N_REQ-1:0]    last_grant;
  logic [CODE_W-1:0]   codes [N_REQ];
  logic [CODE_W-1:0]   code_nxt;
  logic                arb_fire;
  logic                wr_ctrl;
  logic                wr_status;
  logic [31:0]         rd_mux;
  logic                unused_wdata;

  assign unused_wdata = ^writedata;

  for (genvar i = 0; i < N_REQ; i++) begin : g_codes
    assign codes[i] = req_code[i*CODE_W +: CODE_W];
  end

  rr_picker #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_picker (
    .req   (req),
    .ptr   (rr_ptr),
    .valid (pick_valid),
    .index (pick_idx)
  );

  assign arb_fire  = (state == IDLE) && arb_en && !sw_force && pick_valid;
  assign wr_ctrl   = write && (address == REG_CTRL);
  assign wr_status = write && (address == REG_STATUS);

  // Next displayed code; chg compares against it so it sets on the same edge.
  always_comb begin
    code_nxt = screen_code;
    if (sw_force)
      code_nxt = sw_code;
    else if (arb_fire)
      code_nxt = codes[pick_idx];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      rr_ptr      <= '0;
      grant       <= '0;
      last_grant  <= '0;
      screen_code <= '0;
    end else begin
      grant       <= '0;
      screen_code <= code_nxt;
      if (sw_force) begin
        state    <= IDLE;
        hold_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (arb_fire) begin
              grant      <= GRANT_ONE << pick_idx;
              last_grant <= GRANT_ONE << pick_idx;
              rr_ptr     <= (pick_idx == PTR_LAST) ? '0 : pick_idx + 1'b1;
              hold_cnt   <= HOLD_LOAD;
              state      <= HOLD;
            end
          end
          HOLD: begin
            // Leave as the count reaches zero so a grant recurs every MIN_HOLD
            // cycles (every 2 when MIN_HOLD is 1).
            if ((hold_cnt == '0) || (hold_cnt == HOLD_W'(1))) begin
              hold_cnt <= '0;
              state    <= IDLE;
            end else begin
              hold_cnt <= hold_cnt - 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arb_en   <= 1'b0;
      sw_force <= 1'b0;
      sw_code  <= '0;
      chg      <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        arb_en   <= writedata[CTRL_ARB_EN];
        sw_force <= writedata[CTRL_SW_FORCE];
        sw_code  <= writedata[CTRL_SW_CODE_LSB +: CODE_W];
      end
      if (code_nxt != screen_code)
        chg <= 1'b1;
      else if (wr_status && writedata[STATUS_CHG])
        chg <= 1'b0;
    end
  end

`ifdef SCREEN_ARB_IRQ_EN
  logic irq_mask;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (write && (address == REG_IRQMASK))
        irq_mask <= writedata[0];
      irq <= chg & irq_mask;
    end
  end
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    case (address)
      REG_CODE: rd_mux[CODE_W-1:0] = screen_code;
      REG_CTRL: begin
        rd_mux[CTRL_ARB_EN]                    = arb_en;
        rd_mux[CTRL_SW_FORCE]                  = sw_force;
        rd_mux[CTRL_SW_CODE_LSB +: CODE_W]     = sw_code;
      end
      REG_STATUS: begin
        rd_mux[STATUS_CHG]                     = chg;
        rd_mux[STATUS_GRANT_LSB +: N_REQ]      = last_grant;
      end
`ifdef SCREEN_ARB_IRQ_EN
      REG_IRQMASK: rd_mux[0] = irq_mask;
`else
      REG_IRQMASK: rd_mux = '0;
`endif
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      readdata <= '0;
    else
      readdata <= rd_mux;
  end

endmodule

// File: tb/tb_screen_code_arbiter.sv
// Directed bench for screen_code_arbiter: register reads, round-robin order,
// hold spacing, software force, chg/W1C and async reset behaviour.
module tb_screen_code_arbiter;
  import screen_arb_pkg::*;

  localparam int N_REQ    = 4;
  localparam int CODE_W   = 5;
  localparam int MIN_HOLD = 16;
`ifdef SCREEN_ARB_IRQ_EN
  localparam logic IRQ_BUILD = 1'b1;
`else
  localparam logic IRQ_BUILD = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic [1:0]              address;
  logic                    write;
  logic [31:0]             writedata;
  logic [31:0]             readdata;
  logic [N_REQ-1:0]        req;
  logic [N_REQ*CODE_W-1:0] req_code;
  logic [N_REQ-1:0]        grant;
  logic [CODE_W-1:0]       screen_code;
  logic                    irq;

  logic [CODE_W-1:0] code_tab [N_REQ];
  logic [N_REQ-1:0]  exp_q [$];
  logic [N_REQ-1:0]  exp_g;
  logic [31:0]       rd;
  int                n_checks = 0;
  int                n_pass   = 0;
  int                waited;
  int                ng;
  int                gap;
  logic              first;

  always #5 clk = ~clk;

  assign req_code = {code_tab[3], code_tab[2], code_tab[1], code_tab[0]};

  screen_code_arbiter #(
    .N_REQ    (N_REQ),
    .CODE_W   (CODE_W),
    .MIN_HOLD (MIN_HOLD)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .address     (address),
    .write       (write),
    .writedata   (writedata),
    .readdata    (readdata),
    .req         (req),
    .req_code    (req_code),
    .grant       (grant),
    .screen_code (screen_code),
    .irq         (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic av_write(input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    step(1);
    write     = 1'b0;
  endtask

  task automatic av_read(input logic [1:0] a, output logic [31:0] d);
    address = a;
    step(1);
    d = readdata;
  endtask

  // Cycles until a grant appears; budget+1 when none arrives.
  task automatic wait_grant(input int budget, output int cycles);
    cycles = 0;
    do begin
      step(1);
      cycles++;
    end while ((grant == '0) && (cycles <= budget));
  endtask

  function automatic logic [CODE_W-1:0] code_of(input logic [N_REQ-1:0] g);
    code_of = '0;
    for (int i = 0; i < N_REQ; i++)
      if (g[i]) code_of = code_tab[i];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    address   = 2'd0;
    write     = 1'b0;
    writedata = '0;
    req       = '0;
    code_tab[0] = 5'd7;
    code_tab[1] = 5'd3;
    code_tab[2] = 5'd9;
    code_tab[3] = 5'h15;

    // Reset state
    step(3);
    check("rst_grant", grant, 0);
    check("rst_code", screen_code, 0);
    check("rst_irq", irq, 0);
    check("rst_readdata", readdata, 0);
    reset_n = 1'b1;
    av_read(REG_CODE, rd);   check("rd_code_rst", rd, 0);
    av_read(REG_CTRL, rd);   check("rd_ctrl_rst", rd, 0);
    av_read(REG_STATUS, rd); check("rd_status_rst", rd, 0);

    // Two requesters, first grant then hold spacing
    req = 4'b0110;
    av_write(REG_CTRL, 32'h1);
    step(1);
    check("first_grant", grant, 4'b0010);
    check("first_code", screen_code, 3);
    wait_grant(40, waited);
    check("hold_spacing", waited, MIN_HOLD);
    check("second_grant", grant, 4'b0100);
    check("second_code", screen_code, 9);
    req = '0;
    av_read(REG_STATUS, rd);
    check("status_after_two", rd, 32'h401);

    // All requesting: order starts at wrapped rr_ptr=3
    exp_q = '{4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    req   = 4'b1111;
    gap   = 0;
    first = 1'b1;
    for (int c = 0; (c < 200) && (exp_q.size() > 0); c++) begin
      step(1);
      gap++;
      if (grant != '0) begin
        exp_g = exp_q.pop_front();
        check("rr_order", grant, exp_g);
        check("rr_code", screen_code, code_of(exp_g));
        if (!first) check("rr_spacing", gap, MIN_HOLD);
        first = 1'b0;
        gap   = 0;
      end
    end
    check("rr_all_granted", exp_q.size(), 0);

    // Software force mid-hold
    step(3);
    av_write(REG_CTRL, 32'h1203);
    step(1);
    check("force_code", screen_code, 5'h12);
    ng = (grant != '0) ? 1 : 0;
    for (int c = 0; c < 20; c++) begin
      step(1);
      if (grant != '0) ng++;
    end
    check("force_no_grant", ng, 0);
    av_read(REG_CTRL, rd);
    check("rd_ctrl_force", rd, 32'h1203);
    av_write(REG_CTRL, 32'h0A03);
    step(1);
    check("force_recode", screen_code, 5'h0A);
    av_write(REG_CTRL, 32'h1);
    step(1);
    check("resume_grant", grant, 4'b0010);
    check("resume_code", screen_code, 3);
    req = '0;

    // chg clear, same-code re-grant, simultaneous set and W1C
    av_write(REG_STATUS, 32'h1);
    av_read(REG_STATUS, rd);
    check("chg_cleared", rd, 32'h200);
    step(20);
    req = 4'b0010;
    wait_grant(40, waited);
    req = '0;
    check("arb_latency", waited, 1);
    check("regrant", grant, 4'b0010);
    av_read(REG_STATUS, rd);
    check("same_code_no_chg", rd, 32'h200);
    step(20);
    code_tab[1] = 5'h1C;
    req       = 4'b0010;
    address   = REG_STATUS;
    writedata = 32'h1;
    write     = 1'b1;
    step(1);
    write = 1'b0;
    req   = '0;
    check("chg_grant", grant, 4'b0010);
    check("chg_code", screen_code, 5'h1C);
    av_read(REG_STATUS, rd);
    check("set_wins_w1c", rd, 32'h201);
    av_write(REG_STATUS, 32'h1);
    av_read(REG_STATUS, rd);
    check("w1c_clears", rd, 32'h200);

    // arb_en=0 blocks grants and keeps the code
    av_write(REG_CTRL, 32'h0);
    req = 4'b1111;
    ng  = 0;
    for (int c = 0; c < 40; c++) begin
      step(1);
      if (grant != '0) ng++;
    end
    check("disabled_no_grant", ng, 0);
    check("disabled_code", screen_code, 5'h1C);
    req = '0;
    av_write(REG_CODE, 32'h5);
    av_read(REG_CODE, rd);
    check("code_write_ignored", rd, 32'h1C);

    // Interrupt mask and change interrupt
    av_write(REG_IRQMASK, 32'h1);
    av_read(REG_IRQMASK, rd);
    check("rd_irqmask", rd, {31'b0, IRQ_BUILD});
    check("irq_idle", irq, 0);
    av_write(REG_CTRL, 32'h0503);
    step(1);
    check("irq_same_cycle_as_chg", irq, 0);
    step(1);
    check("irq_raised", irq, {31'b0, IRQ_BUILD});
    av_write(REG_STATUS, 32'h1);
    step(1);
    check("irq_cleared", irq, 0);

    // Async reset mid-hold
    req = 4'b0001;
    av_write(REG_CTRL, 32'h1);
    step(1);
    check("pre_rst_grant", grant, 4'b0001);
    check("pre_rst_code", screen_code, 7);
    step(2);
    check("pre_rst_irq", irq, {31'b0, IRQ_BUILD});
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_grant", grant, 0);
    check("async_rst_code", screen_code, 0);
    check("async_rst_irq", irq, 0);
    check("async_rst_readdata", readdata, 0);
    req = '0;
    step(2);
    reset_n = 1'b1;
    av_read(REG_CTRL, rd);   check("ctrl_after_rst", rd, 0);
    av_read(REG_STATUS, rd); check("status_after_rst", rd, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
